// File: rtl/v_pkg.sv
// ---------------------------------------------------------------------------
// v_pkg
// Shared types for the level-0 notify receiver and its report queue.
//
// Contents:
//   CONTEXT_N   number of producer contexts tracked in the shadow table
//   RPT_FIFO_N  default depth of the report queue
//   id_t        producer identifier
//   key_t       level-0 key
//   size_t      level-0 size (0 means the level is empty)
//   rpt_kind_t  kind of change being reported (KEY / SIZE / EMPTY)
//   rpt_t       one queued report {prod_id, key, size, kind}
//   shadow_t    one shadow table entry {vld, key, size}
//   classify()  decides whether a notify produces a report, and of which kind
// ---------------------------------------------------------------------------
package v_pkg;

    localparam int CONTEXT_N  = 8;
    localparam int ID_W       = $clog2(CONTEXT_N);
    localparam int KEY_W      = 8;
    localparam int SIZE_W     = 8;
    localparam int RPT_FIFO_N = 4;

    typedef logic [ID_W-1:0]   id_t;
    typedef logic [KEY_W-1:0]  key_t;
    typedef logic [SIZE_W-1:0] size_t;

    typedef enum logic [1:0] {
        RPT_KEY   = 2'b00,
        RPT_SIZE  = 2'b01,
        RPT_EMPTY = 2'b10
    } rpt_kind_t;

    typedef struct packed {
        id_t       prod_id;
        key_t      key;
        size_t     size;
        rpt_kind_t kind;
    } rpt_t;

    typedef struct packed {
        logic  vld;
        key_t  key;
        size_t size;
    } shadow_t;

    typedef struct packed {
        logic      emit;
        rpt_kind_t kind;
    } cls_t;

    // Compare an incoming level-0 state against what we last saw for that
    // producer. An empty level only matters if the entry was live; a key
    // change (or a previously unknown producer) outranks a size change.
    function automatic cls_t classify(input shadow_t sh, input key_t key, input size_t size);
        cls_t r;
        r.emit = 1'b0;
        r.kind = RPT_KEY;
        if (size == '0) begin
            r.emit = sh.vld;
            r.kind = RPT_EMPTY;
        end else if (!sh.vld || (sh.key != key)) begin
            r.emit = 1'b1;
            r.kind = RPT_KEY;
        end else if (sh.size != size) begin
            r.emit = 1'b1;
            r.kind = RPT_SIZE;
        end
        return r;
    endfunction

endpackage

// File: rtl/v_rpt_fifo.sv
// ---------------------------------------------------------------------------
// v_rpt_fifo
// Synchronous first-word-fall-through queue of rpt_t reports.
//
// Parameters:
//   DEPTH      number of entries, power of two, >= 2
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset, empties the queue
//   flush      synchronous flush, empties the queue
//   push       write push_data (ignored when full unless pop fires too)
//   push_data  report to enqueue
//   pop        remove the head entry (ignored when empty)
//   head       current head entry (undefined content when empty)
//   full       all DEPTH entries occupied
//   empty      no entries occupied
// ---------------------------------------------------------------------------
module v_rpt_fifo
    import v_pkg::*;
#(
    parameter int DEPTH = RPT_FIFO_N
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic push,
    input  rpt_t push_data,
    input  logic pop,
    output rpt_t head,
    output logic full,
    output logic empty
);

    localparam int PTR_W = $clog2(DEPTH);

    rpt_t             mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // without a separate occupancy counter.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    // A push into a full queue still lands when the head leaves in the same
    // cycle: the write goes to the slot being vacated, so occupancy holds.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign head = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

    // Storage needs no reset: entries are only visible once pushed.
    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) begin
            mem[wr_ptr[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/v_lv0_rx.sv
// ---------------------------------------------------------------------------
// v_lv0_rx
// Level-0 notify receiver. Keeps a shadow copy of each producer's level-0
// {key, size}, turns notifies that actually change something into KEY / SIZE
// / EMPTY reports, and queues those reports for a downstream consumer.
//
// Parameters:
//   RPT_FIFO_N        report queue depth, power of two, >= 2
// Ports:
//   clk               clock
//   rst               synchronous active-high reset
//   i_lv0_vld_r       notify valid (one per cycle, no backpressure)
//   i_lv0_prod_id_r   producer whose level 0 changed
//   i_lv0_key_r       new level-0 key
//   i_lv0_size_r      new level-0 size, 0 = empty
//   i_busy_r          list engine initialising: ignore notifies, wipe state
//   o_rpt_vld         report available at queue head
//   i_rpt_rdy         consumer takes the head report
//   o_rpt_prod_id     head report producer id    (0 when !o_rpt_vld)
//   o_rpt_key         head report key            (0 when !o_rpt_vld)
//   o_rpt_size        head report size           (0 when !o_rpt_vld)
//   o_rpt_kind        head report kind           (0 when !o_rpt_vld)
//   i_qry_prod_id     shadow lookup address
//   o_qry_vld         shadow entry valid
//   o_qry_key         shadow key   (0 when entry invalid)
//   o_qry_size        shadow size  (0 when entry invalid)
//   o_drop_cnt_r      saturating count of reports lost to a full queue
//   o_ovf_r           sticky "a report was lost" flag
//   i_clr             clears o_drop_cnt_r and o_ovf_r
// ---------------------------------------------------------------------------
module v_lv0_rx
    import v_pkg::*;
#(
    parameter int RPT_FIFO_N = v_pkg::RPT_FIFO_N
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_lv0_vld_r,
    input  id_t         i_lv0_prod_id_r,
    input  key_t        i_lv0_key_r,
    input  size_t       i_lv0_size_r,
    input  logic        i_busy_r,
    output logic        o_rpt_vld,
    input  logic        i_rpt_rdy,
    output id_t         o_rpt_prod_id,
    output key_t        o_rpt_key,
    output size_t       o_rpt_size,
    output rpt_kind_t   o_rpt_kind,
    input  id_t         i_qry_prod_id,
    output logic        o_qry_vld,
    output key_t        o_qry_key,
    output size_t       o_qry_size,
    output logic [15:0] o_drop_cnt_r,
    output logic        o_ovf_r,
    input  logic        i_clr
);

    shadow_t shadow_q [CONTEXT_N];

    logic    accept;
    shadow_t cur_sh;
    cls_t    cls;
    logic    push_req;
    rpt_t    push_data;

    rpt_t    fifo_head;
    logic    fifo_full;
    logic    fifo_empty;
    logic    rpt_fire;
    logic    drop;

    // Classification runs against the registered shadow, so a notify sees
    // the state left by the previous edge, never its own update.
    always_comb begin
        accept    = i_lv0_vld_r & ~i_busy_r;
        cur_sh    = shadow_q[i_lv0_prod_id_r];
        cls       = classify(cur_sh, i_lv0_key_r, i_lv0_size_r);
        push_req  = accept & cls.emit;
        push_data = '{prod_id: i_lv0_prod_id_r,
                      key:     i_lv0_key_r,
                      size:    i_lv0_size_r,
                      kind:    cls.kind};
    end

    // Shadow table. Busy wipes only the valid bits; stale key/size data is
    // harmless because every read of it is qualified by vld. A dropped report
    // still updates the shadow so later notifies are classified correctly.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CONTEXT_N; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (i_busy_r) begin
            for (int i = 0; i < CONTEXT_N; i++) begin
                shadow_q[i].vld <= 1'b0;
            end
        end else if (push_req) begin
            if (cls.kind == RPT_EMPTY) begin
                shadow_q[i_lv0_prod_id_r].vld <= 1'b0;
            end else begin
                shadow_q[i_lv0_prod_id_r] <= '{vld:  1'b1,
                                               key:  i_lv0_key_r,
                                               size: i_lv0_size_r};
            end
        end
    end

    // Head is hidden while busy; the queue itself is flushed on the next edge.
    assign o_rpt_vld = ~fifo_empty & ~i_busy_r;
    assign rpt_fire  = o_rpt_vld & i_rpt_rdy;

    v_rpt_fifo #(
        .DEPTH     (RPT_FIFO_N)
    ) u_rpt_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (i_busy_r),
        .push      (push_req),
        .push_data (push_data),
        .pop       (rpt_fire),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        o_rpt_prod_id = '0;
        o_rpt_key     = '0;
        o_rpt_size    = '0;
        o_rpt_kind    = RPT_KEY;
        if (o_rpt_vld) begin
            o_rpt_prod_id = fifo_head.prod_id;
            o_rpt_key     = fifo_head.key;
            o_rpt_size    = fifo_head.size;
            o_rpt_kind    = fifo_head.kind;
        end
    end

    // A push is lost only when the queue is full and nothing leaves this cycle.
    assign drop = push_req & fifo_full & ~rpt_fire;

    // Clear wins over the old count but not over a drop in the same cycle,
    // so the lost report is still accounted for.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_drop_cnt_r <= '0;
            o_ovf_r      <= 1'b0;
        end else if (i_clr) begin
            o_drop_cnt_r <= drop ? 16'd1 : 16'd0;
            o_ovf_r      <= drop;
        end else if (drop) begin
            if (o_drop_cnt_r != 16'hFFFF) begin
                o_drop_cnt_r <= o_drop_cnt_r + 16'd1;
            end
            o_ovf_r <= 1'b1;
        end
    end

    // Query port reads registered state only.
    always_comb begin
        o_qry_vld  = shadow_q[i_qry_prod_id].vld;
        o_qry_key  = '0;
        o_qry_size = '0;
        if (o_qry_vld) begin
            o_qry_key  = shadow_q[i_qry_prod_id].key;
            o_qry_size = shadow_q[i_qry_prod_id].size;
        end
    end

endmodule

// File: tb/tb_v_lv0_rx.sv
// ---------------------------------------------------------------------------
// tb_v_lv0_rx
// Directed self-checking bench for v_lv0_rx. Inputs change on the falling
// edge, the DUT samples on the rising edge, outputs are checked on the
// following falling edge.
// ---------------------------------------------------------------------------
module tb_v_lv0_rx;
    import v_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_lv0_vld_r = 1'b0;
    id_t         i_lv0_prod_id_r = '0;
    key_t        i_lv0_key_r = '0;
    size_t       i_lv0_size_r = '0;
    logic        i_busy_r = 1'b0;
    logic        o_rpt_vld;
    logic        i_rpt_rdy = 1'b0;
    id_t         o_rpt_prod_id;
    key_t        o_rpt_key;
    size_t       o_rpt_size;
    rpt_kind_t   o_rpt_kind;
    id_t         i_qry_prod_id = '0;
    logic        o_qry_vld;
    key_t        o_qry_key;
    size_t       o_qry_size;
    logic [15:0] o_drop_cnt_r;
    logic        o_ovf_r;
    logic        i_clr = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    v_lv0_rx #(
        .RPT_FIFO_N      (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_lv0_vld_r     (i_lv0_vld_r),
        .i_lv0_prod_id_r (i_lv0_prod_id_r),
        .i_lv0_key_r     (i_lv0_key_r),
        .i_lv0_size_r    (i_lv0_size_r),
        .i_busy_r        (i_busy_r),
        .o_rpt_vld       (o_rpt_vld),
        .i_rpt_rdy       (i_rpt_rdy),
        .o_rpt_prod_id   (o_rpt_prod_id),
        .o_rpt_key       (o_rpt_key),
        .o_rpt_size      (o_rpt_size),
        .o_rpt_kind      (o_rpt_kind),
        .i_qry_prod_id   (i_qry_prod_id),
        .o_qry_vld       (o_qry_vld),
        .o_qry_key       (o_qry_key),
        .o_qry_size      (o_qry_size),
        .o_drop_cnt_r    (o_drop_cnt_r),
        .o_ovf_r         (o_ovf_r),
        .i_clr           (i_clr)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    // Guard against an unexpected hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic vld, input int id, input int key, input int size);
        i_lv0_vld_r     = vld;
        i_lv0_prod_id_r = id_t'(id);
        i_lv0_key_r     = key_t'(key);
        i_lv0_size_r    = size_t'(size);
    endtask

    // One notify for exactly one clock.
    task automatic notify(input int id, input int key, input int size);
        applyStimulus(1'b1, id, key, size);
        tick();
        applyStimulus(1'b0, 0, 0, 0);
    endtask

    task automatic popOne();
        i_rpt_rdy = 1'b1;
        tick();
        i_rpt_rdy = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic checkReport(input string tag, input logic vld, input int id,
                               input int key, input int size, input rpt_kind_t kind);
        logic [31:0] obs;
        logic [31:0] exp;
        obs = 32'({o_rpt_vld, o_rpt_prod_id, o_rpt_key, o_rpt_size, o_rpt_kind});
        exp = 32'({vld, id_t'(id), key_t'(key), size_t'(size), kind});
        checkOutput(tag, obs, exp);
    endtask

    task automatic checkQuery(input string tag, input int id, input logic vld,
                              input int key, input int size);
        logic [31:0] obs;
        logic [31:0] exp;
        i_qry_prod_id = id_t'(id);
        #1;
        obs = 32'({o_qry_vld, o_qry_key, o_qry_size});
        exp = 32'({vld, key_t'(key), size_t'(size)});
        checkOutput(tag, obs, exp);
    endtask

    task automatic checkCounters(input string tag, input int cnt, input logic ovf);
        checkOutput({tag, "_cnt"}, 32'(o_drop_cnt_r), 32'(cnt));
        checkOutput({tag, "_ovf"}, 32'(o_ovf_r), 32'(ovf));
    endtask

    initial begin
        // Reset state.
        tick();
        tick();
        checkReport("rst_rpt", 1'b0, 0, 0, 0, RPT_KEY);
        checkCounters("rst", 0, 1'b0);
        checkQuery("rst_qry3", 3, 1'b0, 0, 0);
        rst = 1'b0;
        tick();

        // First notify for id 3 becomes a KEY report one cycle later.
        notify(3, 8'h10, 5);
        checkReport("key_rpt", 1'b1, 3, 8'h10, 5, RPT_KEY);
        checkQuery("key_qry3", 3, 1'b1, 8'h10, 5);
        popOne();
        checkReport("key_popped", 1'b0, 0, 0, 0, RPT_KEY);

        // Same key, new size.
        notify(3, 8'h10, 7);
        checkReport("size_rpt", 1'b1, 3, 8'h10, 7, RPT_SIZE);
        popOne();

        // Identical state is suppressed.
        notify(3, 8'h10, 7);
        checkReport("dup_suppr", 1'b0, 0, 0, 0, RPT_KEY);

        // Size 0 empties the level.
        notify(3, 8'h10, 0);
        checkReport("empty_rpt", 1'b1, 3, 8'h10, 0, RPT_EMPTY);
        checkQuery("empty_qry3", 3, 1'b0, 0, 0);
        popOne();

        // Emptying an already-invalid entry is suppressed.
        notify(3, 8'h11, 0);
        checkReport("empty_suppr", 1'b0, 0, 0, 0, RPT_KEY);

        // Six notifies into a stalled 4-deep queue: two drops.
        for (int i = 0; i < 6; i++) notify(i, 8'h20 + i, 1 + i);
        checkCounters("ovf6", 2, 1'b1);
        checkQuery("ovf_qry5", 5, 1'b1, 8'h25, 6);
        for (int i = 0; i < 4; i++) begin
            checkReport($sformatf("ovf_head%0d", i), 1'b1, i, 8'h20 + i, 1 + i, RPT_KEY);
            popOne();
        end
        checkReport("ovf_drained", 1'b0, 0, 0, 0, RPT_KEY);
        i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
        checkCounters("clr", 0, 1'b0);

        // Full queue with a pop and a push in the same cycle: nothing lost.
        for (int i = 0; i < 4; i++) notify(i, 8'h30 + i, 2);
        i_rpt_rdy = 1'b1;
        applyStimulus(1'b1, 4, 8'h34, 9);
        tick();
        applyStimulus(1'b0, 0, 0, 0);
        i_rpt_rdy = 1'b0;
        checkCounters("fullpp", 0, 1'b0);
        for (int i = 1; i < 5; i++) begin
            if (i < 4) checkReport($sformatf("fullpp_head%0d", i), 1'b1, i, 8'h30 + i, 2, RPT_KEY);
            else       checkReport("fullpp_head4", 1'b1, 4, 8'h34, 9, RPT_KEY);
            popOne();
        end
        checkReport("fullpp_drained", 1'b0, 0, 0, 0, RPT_KEY);

        // Clear coinciding with a drop leaves count 1 and flag set.
        for (int i = 0; i < 4; i++) notify(i, 8'h40 + i, 3);
        notify(4, 8'h44, 3);
        checkCounters("drop1", 1, 1'b1);
        applyStimulus(1'b1, 5, 8'h45, 3);
        i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
        applyStimulus(1'b0, 0, 0, 0);
        checkCounters("clrdrop", 1, 1'b1);

        // Busy for two cycles with notifies: queue flushed, shadow wiped.
        i_busy_r = 1'b1;
        applyStimulus(1'b1, 6, 8'h50, 1);
        tick();
        checkReport("busy_rpt", 1'b0, 0, 0, 0, RPT_KEY);
        tick();
        i_busy_r = 1'b0;
        applyStimulus(1'b0, 0, 0, 0);
        #1;
        checkReport("busy_after", 1'b0, 0, 0, 0, RPT_KEY);
        checkCounters("busy", 1, 1'b1);
        for (int i = 0; i < CONTEXT_N; i++) checkQuery($sformatf("busy_qry%0d", i), i, 1'b0, 0, 0);
        tick();
        checkReport("busy_late", 1'b0, 0, 0, 0, RPT_KEY);
        notify(6, 8'h50, 1);
        checkReport("post_busy", 1'b1, 6, 8'h50, 1, RPT_KEY);
        popOne();

        // Reset with three reports queued.
        for (int i = 0; i < 3; i++) notify(i, 8'h60 + i, 4);
        checkReport("preq_head", 1'b1, 0, 8'h60, 4, RPT_KEY);
        rst = 1'b1;
        tick();
        checkReport("rst2_rpt", 1'b0, 0, 0, 0, RPT_KEY);
        checkCounters("rst2", 0, 1'b0);
        rst = 1'b0;
        tick();
        checkReport("rst2_idle", 1'b0, 0, 0, 0, RPT_KEY);
        notify(2, 8'h60, 4);
        checkReport("rst2_first", 1'b1, 2, 8'h60, 4, RPT_KEY);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/v_lv0_rx.md
V_LV0_RX -- requirements
Module: v_lv0_rx

Interface
REQ-001 Parameter: RPT_FIFO_N, default v_pkg::RPT_FIFO_N (4), report FIFO depth, power of two, >=2.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 i_lv0_vld_r  input  1  notify-bus valid, one entry per cycle, no backpressure.
REQ-005 i_lv0_prod_id_r  input  v_pkg::id_t  producer whose level 0 changed.
REQ-006 i_lv0_key_r  input  v_pkg::key_t  new level-0 key.
REQ-007 i_lv0_size_r  input  v_pkg::size_t  new level-0 size; 0 = level empty.
REQ-008 i_busy_r  input  1  list engine initialising.
REQ-009 o_rpt_vld  output  1  report available (FIFO not empty).
REQ-010 i_rpt_rdy  input  1  consumer accepts report; transfer when o_rpt_vld and i_rpt_rdy.
REQ-011 o_rpt_prod_id / o_rpt_key / o_rpt_size / o_rpt_kind  output  id_t / key_t / size_t / v_pkg::rpt_kind_t  FIFO-head report fields.
REQ-012 i_qry_prod_id  input  id_t  shadow lookup address; o_qry_vld 1, o_qry_key key_t, o_qry_size size_t  outputs, combinational shadow read.
REQ-013 o_drop_cnt_r  output  16  saturating count of reports dropped on FIFO full; o_ovf_r  output  1  sticky drop flag; i_clr  input  1  clears both.

Function
REQ-014 Shadow table SHALL hold, per id (v_pkg::CONTEXT_N entries), valid bit, key, size.
REQ-015 Accepted notify (i_lv0_vld_r & !i_busy_r) SHALL classify against shadow[id] in the same cycle: size==0 -> EMPTY; shadow invalid or key differs -> KEY; key equal, size differs -> SIZE; key and size equal with shadow valid -> suppressed (no report).
REQ-016 EMPTY SHALL clear shadow valid; KEY/SIZE SHALL write key, size, valid=1; EMPTY on already-invalid entry SHALL be suppressed.
REQ-017 Non-suppressed notify SHALL push {id, key, size, kind} into FIFO; o_rpt_vld SHALL rise the cycle after the notify when FIFO was empty (latency 1).
REQ-018 Push when full SHALL be dropped unless a pop occurs the same cycle, in which case push and pop both complete and occupancy is unchanged.
REQ-019 Drop SHALL increment o_drop_cnt_r (saturating at 16'hFFFF) and set o_ovf_r; shadow update SHALL still occur.
REQ-020 i_clr and a drop in the same cycle SHALL yield o_drop_cnt_r=1, o_ovf_r=1.
REQ-021 Report fields SHALL remain stable while o_rpt_vld & !i_rpt_rdy; FIFO order SHALL be arrival order.
REQ-022 Query outputs SHALL reflect shadow state after the last clock edge (no bypass of same-cycle notify).
REQ-023 While i_busy_r=1: notifies ignored, all shadow valid bits cleared each cycle, FIFO flushed, o_rpt_vld=0; counters retained.

Reset
REQ-024 On rst: shadow valid all 0, FIFO empty, o_rpt_vld=0, o_drop_cnt_r=0, o_ovf_r=0; data outputs 0 when not valid.
REQ-025 rst mid-transfer SHALL discard queued reports; first report after rst deasserts follows REQ-017.

Structure
REQ-026 v_pkg SHALL add rpt_kind_t (KEY=2'b00, SIZE=2'b01, EMPTY=2'b10) and RPT_FIFO_N=4; reuse id_t, key_t, size_t, CONTEXT_N.
REQ-027 Report queue SHALL be a sub-module v_rpt_fifo (synchronous, flush input, full/empty outputs); shadow table in flops within v_lv0_rx.

Verification
REQ-028 Reset, id=3 key=0x10 size=5 -> next cycle report {3,0x10,5,KEY}; o_qry(3)={1,0x10,5}.
REQ-029 Then id=3 key=0x10 size=7 -> SIZE; repeat size=7 -> no report; size=0 -> EMPTY, o_qry_vld(3)=0.
REQ-030 i_rpt_rdy=0, six distinct notifies -> four reports held in order, o_drop_cnt_r=2, o_ovf_r=1; i_clr -> both 0.
REQ-031 FIFO full, rdy=1 and notify same cycle -> no drop, occupancy stays 4, order preserved.
REQ-032 Shadow populated, FIFO non-empty, i_busy_r=1 two cycles with notifies -> o_rpt_vld=0, all o_qry_vld=0, no reports after busy drops.
REQ-033 rst asserted with 3 queued reports -> o_rpt_vld=0 next cycle, counters 0.
